// File: rtl/spi_sram_ctrl.sv
// Command sequencer between the SPI slave byte interface and the on-chip SRAM.
// Decodes write/read/status commands, runs auto-incrementing bursts and keeps tx_data one byte ahead.
module spi_sram_ctrl #(
    parameter int AW         = 10,
    parameter int ADDR_BYTES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          msg_start,
    input  logic          msg_end,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic [7:0]    tx_data,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata,
    output logic          sram_we,
    output logic          sram_re,
    input  logic [7:0]    sram_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RPRE, RDATA, STAT, IGNORE
    } state_t;

    localparam logic [7:0] LAST_ADDR_BYTE = 8'(ADDR_BYTES - 1);

    state_t     state;
    logic       mode_rd;
    logic [7:0] byte_cnt;
    logic [7:0] wr_count;
    logic       rd_wait;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_rd    <= 1'b0;
            byte_cnt   <= 8'd0;
            wr_count   <= 8'd0;
            rd_wait    <= 1'b0;
            tx_data    <= 8'h00;
            sram_addr  <= '0;
            sram_wdata <= 8'h00;
            sram_we    <= 1'b0;
            sram_re    <= 1'b0;
        end else begin
            sram_we <= 1'b0;
            sram_re <= 1'b0;
            rd_wait <= sram_re;

            // A write strobe issued last cycle has landed: advance the burst.
            if (sram_we) begin
                sram_addr <= sram_addr + AW'(1);
                if (wr_count != 8'hFF)
                    wr_count <= wr_count + 8'd1;
            end

            if (msg_start) begin
                state    <= CMD;
                tx_data  <= 8'hA5;
                byte_cnt <= 8'd0;
                rd_wait  <= 1'b0;
            end else if (msg_end) begin
                state   <= IDLE;
                rd_wait <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (rx_valid) begin
                            case (rx_data)
                                8'h02: begin state <= ADDR; mode_rd <= 1'b0; end
                                8'h03: begin state <= ADDR; mode_rd <= 1'b1; end
                                8'h05: begin state <= STAT; tx_data <= wr_count; end
                                default: begin state <= IGNORE; tx_data <= 8'hFF; end
                            endcase
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            // Shifting through an AW-bit register drops the surplus high bits.
                            sram_addr <= AW'({sram_addr, rx_data});
                            byte_cnt  <= byte_cnt + 8'd1;
                            if (byte_cnt == LAST_ADDR_BYTE) begin
                                if (mode_rd) begin
                                    state   <= RPRE;
                                    sram_re <= 1'b1;
                                end else begin
                                    state    <= WDATA;
                                    wr_count <= 8'd0;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (rx_valid) begin
                            sram_we    <= 1'b1;
                            sram_wdata <= rx_data;
                        end
                    end
                    RPRE: begin
                        if (rd_wait) begin
                            tx_data   <= sram_rdata;
                            sram_addr <= sram_addr + AW'(1);
                            state     <= RDATA;
                        end
                    end
                    RDATA: begin
                        // Prefetch the byte for the next boundary as soon as this one is consumed.
                        if (rd_wait) begin
                            tx_data   <= sram_rdata;
                            sram_addr <= sram_addr + AW'(1);
                        end else if (rx_valid) begin
                            sram_re <= 1'b1;
                        end
                    end
                    STAT:    tx_data <= wr_count;
                    IGNORE:  tx_data <= 8'hFF;
                    default: ;
                endcase
            end
        end
    end

endmodule
